system_memory_v3: RTL and testbench

Grid state memory for the Conway engine, generalised to a W x H grid and multi-lane serial I/O. Its four modes are: serial load from the external interface, run (capture each generation from the grid calculator), serial dump (non-destructive readout) and idle. The block sits between the serial interface and the grid calculator. It adds a load/dump handshake, a mode FSM and a generation counter.

---
 rtl/system_memory_v3_if.sv | 38 +++
 rtl/system_memory_v3.sv | 134 +++++++++++++
 tb/tb_system_memory_v3.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/system_memory_v3_if.sv
// Bus bundle between the grid memory, the serial interface and the grid calculator.
// slave = memory side, master = environment side.
interface system_memory_v3_if #(
   parameter int N         = 64,
   parameter int LANES     = 1,
   parameter int GEN_WIDTH = 16
);
   logic [N-1:0]         grid_in;
   logic                 grid_valid;
   logic [LANES-1:0]     serial_in;
   logic                 serial_valid;
   logic                 load_start;
   logic                 dump_start;
   logic                 run_en;
   logic [LANES-1:0]     serial_out;
   logic                 serial_out_valid;
   logic                 serial_out_ready;
   logic [N-1:0]         data_out;
   logic [1:0]           mode;
   logic                 busy;
   logic                 load_done;
   logic [GEN_WIDTH-1:0] generation;
   logic                 stable;

   modport slave (
      input  grid_in, grid_valid, serial_in, serial_valid, load_start, dump_start,
             run_en, serial_out_ready,
      output serial_out, serial_out_valid, data_out, mode, busy, load_done,
             generation, stable
   );

   modport master (
      output grid_in, grid_valid, serial_in, serial_valid, load_start, dump_start,
             run_en, serial_out_ready,
      input  serial_out, serial_out_valid, data_out, mode, busy, load_done,
             generation, stable
   );
endinterface

// File: rtl/system_memory_v3.sv
// Conway grid state memory: serial load, run capture, non-destructive serial dump, idle.
// Optional STABLE_DETECT_EN macro enables the "grid unchanged" flag.
module system_memory_v3 #(
   parameter int GRID_WIDTH  = 8,
   parameter int GRID_HEIGHT = 8,
   parameter int LANES       = 1,
   parameter int GEN_WIDTH   = 16
) (
   input logic                clk_i,
   input logic                rst_ni,
   system_memory_v3_if.slave  bus
);
   localparam int N     = GRID_WIDTH * GRID_HEIGHT;
   localparam int BEATS = N / LANES;
   localparam int CW    = $clog2(BEATS + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DUMP = 2'd3} mode_e;

   mode_e                mode_q, mode_d;
   logic [N-1:0]         data_q, data_d, shadow_q, shadow_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [GEN_WIDTH-1:0] gen_q, gen_d;
   logic                 ld_q, ld_d, sov_q, sov_d;
   logic                 last_beat;

   assign last_beat = (cnt_q == CW'(BEATS - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mode_q   <= IDLE;
         data_q   <= '0;
         shadow_q <= '0;
         cnt_q    <= '0;
         gen_q    <= '0;
         ld_q     <= 1'b0;
         sov_q    <= 1'b0;
      end else begin
         mode_q   <= mode_d;
         data_q   <= data_d;
         shadow_q <= shadow_d;
         cnt_q    <= cnt_d;
         gen_q    <= gen_d;
         ld_q     <= ld_d;
         sov_q    <= sov_d;
      end
   end

   always_comb begin
      mode_d   = mode_q;
      data_d   = data_q;
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      gen_d    = gen_q;
      ld_d     = 1'b0;
      sov_d    = sov_q;
      unique case (mode_q)
         IDLE: begin
            if (bus.load_start) begin
               mode_d = LOAD;
               cnt_d  = '0;
            end else if (bus.dump_start) begin
               mode_d   = DUMP;
               shadow_d = data_q;
               cnt_d    = '0;
               sov_d    = 1'b1;
            end else if (bus.run_en) begin
               mode_d = RUN;
            end
         end
         LOAD: begin
            // First beat ends up in the MSBs once all BEATS have been shifted in.
            if (bus.serial_valid) begin
               data_d = (data_q << LANES) | N'(bus.serial_in);
               cnt_d  = cnt_q + CW'(1);
               if (last_beat) begin
                  mode_d = IDLE;
                  gen_d  = '0;
                  ld_d   = 1'b1;
               end
            end
         end
         RUN: begin
            if (!bus.run_en) begin
               mode_d = IDLE;
            end else if (bus.grid_valid) begin
               data_d = bus.grid_in;
               gen_d  = gen_q + GEN_WIDTH'(1);
            end
         end
         DUMP: begin
            // Valid is always high here, so ready alone completes a transfer.
            if (bus.serial_out_ready) begin
               shadow_d = shadow_q << LANES;
               cnt_d    = cnt_q + CW'(1);
               if (last_beat) begin
                  mode_d = IDLE;
                  sov_d  = 1'b0;
               end
            end
         end
         default: mode_d = IDLE;
      endcase
   end

`ifdef STABLE_DETECT_EN
   logic stable_q, stable_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) stable_q <= 1'b0;
      else         stable_q <= stable_d;
   end

   // Compare against the pre-update grid, so it reflects the generation just computed.
   always_comb begin
      stable_d = stable_q;
      if (mode_q == LOAD && bus.serial_valid && last_beat)
         stable_d = 1'b0;
      else if (mode_q == RUN && bus.run_en && bus.grid_valid)
         stable_d = (bus.grid_in == data_q);
   end

   assign bus.stable = stable_q;
`else
   assign bus.stable = 1'b0;
`endif

   assign bus.data_out         = data_q;
   assign bus.mode             = mode_q;
   assign bus.busy             = (mode_q != IDLE);
   assign bus.load_done        = ld_q;
   assign bus.generation       = gen_q;
   assign bus.serial_out_valid = sov_q;
   assign bus.serial_out       = sov_q ? shadow_q[N-1 -: LANES] : '0;
endmodule

// File: tb/tb_system_memory_v3.sv
// Bench for system_memory_v3 on a 4x4 grid, 4 lanes, 2-bit generation counter.
module tb_system_memory_v3;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   system_memory_v3_if #(.N(16), .LANES(4), .GEN_WIDTH(2)) bus ();

   system_memory_v3 #(.GRID_WIDTH(4), .GRID_HEIGHT(4), .LANES(4), .GEN_WIDTH(2)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus.slave)
   );

`ifdef STABLE_DETECT_EN
   localparam bit STAB = 1'b1;
`else
   localparam bit STAB = 1'b0;
`endif

   typedef struct {
      logic ls, ds, run, sv; logic [3:0] si; logic gv; logic [15:0] gi; logic rdy;
      logic [1:0] em; logic [15:0] ed; logic [1:0] eg; logic eld, esov; logic [3:0] eso;
   } vec_t;

   vec_t tbl[26];

   function automatic vec_t mk(logic ls, ds, run, sv, logic [3:0] si, logic gv, logic [15:0] gi,
                               logic rdy, logic [1:0] em, logic [15:0] ed, logic [1:0] eg,
                               logic eld, esov, logic [3:0] eso);
      vec_t v;
      v.ls = ls; v.ds = ds; v.run = run; v.sv = sv; v.si = si; v.gv = gv; v.gi = gi; v.rdy = rdy;
      v.em = em; v.ed = ed; v.eg = eg; v.eld = eld; v.esov = esov; v.eso = eso;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic ls, ds, run, sv, input logic [3:0] si, input logic gv,
                        input logic [15:0] gi, input logic rdy);
      bus.load_start = ls; bus.dump_start = ds; bus.run_en = run; bus.serial_valid = sv;
      bus.serial_in = si; bus.grid_valid = gv; bus.grid_in = gi; bus.serial_out_ready = rdy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: transaction-level view of the block.
   int         m_mode, m_cnt;
   bit [15:0]  m_data;
   bit [1:0]   m_gen;
   bit         m_ld, m_st;
   bit [3:0]   m_q[$];

   task automatic model_step();
      m_ld = 1'b0;
      case (m_mode)
         0: if (bus.load_start) begin m_mode = 1; m_cnt = 0; end
            else if (bus.dump_start) begin
               m_mode = 3; m_q.delete();
               for (int i = 3; i >= 0; i--) m_q.push_back(m_data[i*4 +: 4]);
            end else if (bus.run_en) m_mode = 2;
         1: if (bus.serial_valid) begin
               m_data = {m_data[11:0], bus.serial_in};
               m_cnt++;
               if (m_cnt == 4) begin m_mode = 0; m_gen = 0; m_ld = 1; m_st = 0; end
            end
         2: if (!bus.run_en) m_mode = 0;
            else if (bus.grid_valid) begin
               if (STAB) m_st = (bus.grid_in == m_data);
               m_data = bus.grid_in;
               m_gen++;
            end
         default: if (bus.serial_out_ready) begin
               void'(m_q.pop_front());
               if (m_q.size() == 0) m_mode = 0;
            end
      endcase
   endtask

   task automatic load4(input logic [15:0] v);
      drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
      for (int i = 3; i >= 0; i--) begin
         drive(0, 0, 0, 1, v[i*4 +: 4], 0, 0, 0); tick();
      end
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #12;
      chk("rst_data", bus.data_out, 0);
      chk("rst_mode", bus.mode, 0);
      chk("rst_gen", bus.generation, 0);
      chk("rst_outs", {bus.load_done, bus.serial_out_valid, bus.serial_out, bus.stable, bus.busy}, 0);
      rst_n = 1'b1;

      //          ls ds rn sv si    gv gi        rdy  em ed        eg ld sov so
      tbl[0]  = mk(1, 0, 0, 0, 4'h0, 0, 16'h0000, 0,   1, 16'h0000, 0, 0, 0, 4'h0);
      tbl[1]  = mk(0, 0, 0, 1, 4'hA, 0, 16'h0000, 0,   1, 16'h000A, 0, 0, 0, 4'h0);
      tbl[2]  = mk(0, 0, 0, 0, 4'h7, 0, 16'h0000, 0,   1, 16'h000A, 0, 0, 0, 4'h0);
      tbl[3]  = mk(0, 0, 0, 1, 4'h5, 0, 16'h0000, 0,   1, 16'h00A5, 0, 0, 0, 4'h0);
      tbl[4]  = mk(0, 0, 0, 1, 4'hF, 0, 16'h0000, 0,   1, 16'h0A5F, 0, 0, 0, 4'h0);
      tbl[5]  = mk(0, 0, 1, 0, 4'h3, 0, 16'h0000, 0,   1, 16'h0A5F, 0, 0, 0, 4'h0);
      tbl[6]  = mk(0, 0, 0, 1, 4'h0, 0, 16'h0000, 0,   0, 16'hA5F0, 0, 1, 0, 4'h0);
      tbl[7]  = mk(0, 0, 0, 0, 4'h0, 0, 16'h0000, 0,   0, 16'hA5F0, 0, 0, 0, 4'h0);
      tbl[8]  = mk(0, 1, 0, 0, 4'h0, 0, 16'h0000, 0,   3, 16'hA5F0, 0, 0, 1, 4'hA);
      tbl[9]  = mk(0, 0, 0, 0, 4'h0, 0, 16'h0000, 1,   3, 16'hA5F0, 0, 0, 1, 4'h5);
      tbl[10] = mk(1, 0, 0, 0, 4'h0, 0, 16'h0000, 0,   3, 16'hA5F0, 0, 0, 1, 4'h5);
      tbl[11] = mk(0, 0, 1, 1, 4'h9, 1, 16'hFFFF, 1,   3, 16'hA5F0, 0, 0, 1, 4'hF);
      tbl[12] = mk(0, 0, 0, 0, 4'h0, 0, 16'h0000, 1,   3, 16'hA5F0, 0, 0, 1, 4'h0);
      tbl[13] = mk(0, 0, 0, 0, 4'h0, 0, 16'h0000, 0,   3, 16'hA5F0, 0, 0, 1, 4'h0);
      tbl[14] = mk(0, 0, 0, 0, 4'h0, 0, 16'h0000, 1,   0, 16'hA5F0, 0, 0, 0, 4'h0);
      tbl[15] = mk(0, 0, 1, 0, 4'h0, 1, 16'h0009, 0,   2, 16'hA5F0, 0, 0, 0, 4'h0);
      tbl[16] = mk(0, 0, 1, 0, 4'h0, 1, 16'h0001, 0,   2, 16'h0001, 1, 0, 0, 4'h0);
      tbl[17] = mk(0, 0, 1, 0, 4'h0, 1, 16'h0002, 0,   2, 16'h0002, 2, 0, 0, 4'h0);
      tbl[18] = mk(0, 1, 1, 0, 4'h0, 1, 16'h0003, 0,   2, 16'h0003, 3, 0, 0, 4'h0);
      tbl[19] = mk(0, 0, 1, 0, 4'h0, 1, 16'h0004, 0,   2, 16'h0004, 0, 0, 0, 4'h0);
      tbl[20] = mk(0, 0, 1, 0, 4'h0, 1, 16'h0005, 0,   2, 16'h0005, 1, 0, 0, 4'h0);
      tbl[21] = mk(0, 0, 0, 0, 4'h0, 1, 16'h0006, 0,   0, 16'h0005, 1, 0, 0, 4'h0);
      tbl[22] = mk(1, 1, 0, 0, 4'h0, 0, 16'h0000, 0,   1, 16'h0005, 1, 0, 0, 4'h0);
      tbl[23] = mk(0, 1, 1, 0, 4'h0, 0, 16'h0000, 0,   1, 16'h0005, 1, 0, 0, 4'h0);
      tbl[24] = mk(0, 0, 0, 1, 4'h1, 0, 16'h0000, 0,   1, 16'h0051, 1, 0, 0, 4'h0);
      tbl[25] = mk(0, 0, 0, 1, 4'h2, 0, 16'h0000, 0,   1, 16'h0512, 1, 0, 0, 4'h0);

      for (int i = 0; i < 26; i++) begin
         drive(tbl[i].ls, tbl[i].ds, tbl[i].run, tbl[i].sv, tbl[i].si, tbl[i].gv, tbl[i].gi, tbl[i].rdy);
         tick();
         chk($sformatf("v%0d_mode", i), bus.mode, tbl[i].em);
         chk($sformatf("v%0d_data", i), bus.data_out, tbl[i].ed);
         chk($sformatf("v%0d_gen", i), bus.generation, tbl[i].eg);
         chk($sformatf("v%0d_ld", i), bus.load_done, tbl[i].eld);
         chk($sformatf("v%0d_sov", i), bus.serial_out_valid, tbl[i].esov);
         chk($sformatf("v%0d_so", i), bus.serial_out, tbl[i].eso);
         chk($sformatf("v%0d_busy", i), bus.busy, tbl[i].em != 0);
      end

      // Asynchronous reset mid-load: takes effect before the next edge.
      drive(0, 0, 0, 1, 4'h3, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_data", bus.data_out, 0);
      chk("arst_mode", bus.mode, 0);
      tick();
      chk("arst_ld", bus.load_done, 0);
      rst_n = 1'b1;
      load4(16'h1234);
      chk("reload_data", bus.data_out, 16'h1234);
      chk("reload_ld", bus.load_done, 1);
      chk("reload_mode", bus.mode, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
      chk("reload_ld_off", bus.load_done, 0);

      // Stable detection around a still-life block pattern.
      load4(16'h0660);
      chk("st_load", bus.stable, 0);
      drive(0, 0, 1, 0, 0, 0, 0, 0); tick();
      drive(0, 0, 1, 0, 0, 1, 16'h0660, 0); tick();
      chk("st_same", bus.stable, STAB);
      drive(0, 0, 1, 0, 0, 1, 16'h0000, 0); tick();
      chk("st_diff", bus.stable, 0);
      chk("st_data", bus.data_out, 0);
      drive(0, 0, 1, 0, 0, 1, 16'h0000, 0); tick();
      chk("st_same2", bus.stable, STAB);
      drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
      load4(16'hBEEF);
      chk("st_clr_on_load", bus.stable, 0);

      // Randomized run against the reference model from a clean reset.
      rst_n = 1'b0; #1; rst_n = 1'b1;
      m_mode = 0; m_cnt = 0; m_data = 0; m_gen = 0; m_ld = 0; m_st = 0; m_q.delete();
      for (int c = 0; c < 500; c++) begin
         drive($urandom_range(7) == 0, $urandom_range(5) == 0, $urandom_range(9) < 7,
               $urandom_range(1) == 1, 4'($urandom), $urandom_range(1) == 1,
               ($urandom_range(7) == 0) ? bus.data_out : 16'($urandom),
               $urandom_range(4) < 3);
         model_step();
         tick();
         chk("rnd_mode", bus.mode, m_mode);
         chk("rnd_data", bus.data_out, m_data);
         chk("rnd_gen", bus.generation, m_gen);
         chk("rnd_ld", bus.load_done, m_ld);
         chk("rnd_sov", bus.serial_out_valid, m_mode == 3);
         chk("rnd_so", bus.serial_out, (m_mode == 3) ? m_q[0] : 4'h0);
         chk("rnd_busy", bus.busy, m_mode != 0);
         chk("rnd_stable", bus.stable, m_st);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
